// File: rtl/wf_ready_bits_table.sv
// Per-wavefront ready-info table: two write ports and one clear port, with
// registered entry, valid, valid-count and out-of-range id outputs.
module wf_ready_bits_table #(
    parameter int INFO_LENGTH  = 8,
    parameter int WF_PER_CU    = 40,
    parameter int WF_ID_LENGTH = 6,
    parameter int MODE         = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr0_en,
    input  logic [WF_ID_LENGTH-1:0]           wr0_addr,
    input  logic [INFO_LENGTH-1:0]            wr0_data,
    input  logic                              wr1_en,
    input  logic [WF_ID_LENGTH-1:0]           wr1_addr,
    input  logic [INFO_LENGTH-1:0]            wr1_data,
    input  logic                              clr_en,
    input  logic [WF_ID_LENGTH-1:0]           clr_addr,
    output logic [INFO_LENGTH*WF_PER_CU-1:0]  out,
    output logic [WF_PER_CU-1:0]              valid,
    output logic [WF_ID_LENGTH:0]             valid_cnt,
    output logic                              addr_err
);

    localparam int CNT_W = WF_ID_LENGTH + 1;

    logic [INFO_LENGTH*WF_PER_CU-1:0] entries_q, entries_d;
    logic [WF_PER_CU-1:0]             valid_q, valid_d;
    logic [CNT_W-1:0]                 validCnt_q, validCnt_d;
    logic                             addrErr_q, addrErr_d;

    logic wr0InRange, wr1InRange, clrInRange;
    logic wr0Ok, wr1Ok, clrOk;

    function automatic logic idInRange(input logic [WF_ID_LENGTH-1:0] id);
        return 32'(id) < 32'(WF_PER_CU);
    endfunction

    // Out-of-range ids are dropped here, so the entry logic only sees legal requests.
    always_comb begin
        wr0InRange = idInRange(wr0_addr);
        wr1InRange = idInRange(wr1_addr);
        clrInRange = idInRange(clr_addr);
        wr0Ok      = wr0_en && wr0InRange;
        wr1Ok      = wr1_en && wr1InRange;
        clrOk      = clr_en && clrInRange;
        addrErr_d  = (wr0_en && !wr0InRange) ||
                     (wr1_en && !wr1InRange) ||
                     (clr_en && !clrInRange);
    end

    always_comb begin
        logic                   hit0;
        logic                   hit1;
        logic                   clrHit;
        logic [INFO_LENGTH-1:0] wrData;
        logic [INFO_LENGTH-1:0] baseData;

        hit0      = 1'b0;
        hit1      = 1'b0;
        clrHit    = 1'b0;
        wrData    = '0;
        baseData  = '0;
        entries_d = entries_q;
        valid_d   = valid_q;

        for (int i = 0; i < WF_PER_CU; i++) begin
            hit0   = wr0Ok && (wr0_addr == WF_ID_LENGTH'(i));
            hit1   = wr1Ok && (wr1_addr == WF_ID_LENGTH'(i));
            clrHit = clrOk && (clr_addr == WF_ID_LENGTH'(i));
            // Masking with the hit keeps data from a disabled port (even X) out of the entry.
            wrData = ({INFO_LENGTH{hit0}} & wr0_data) |
                     ({INFO_LENGTH{hit1}} & wr1_data);
            // A same-cycle clear happens before the write, so accumulation starts from zero.
            baseData = clrHit ? '0 : entries_q[i*INFO_LENGTH +: INFO_LENGTH];

            if (hit0 || hit1) begin
                if (MODE == 1) begin
                    entries_d[i*INFO_LENGTH +: INFO_LENGTH] = baseData | wrData;
                end else begin
                    entries_d[i*INFO_LENGTH +: INFO_LENGTH] = wrData;
                end
                valid_d[i] = 1'b1;
            end else if (clrHit) begin
                entries_d[i*INFO_LENGTH +: INFO_LENGTH] = '0;
                valid_d[i] = 1'b0;
            end
        end
    end

    // Counting the next-state flags keeps valid_cnt in step with valid.
    always_comb begin
        validCnt_d = '0;
        for (int i = 0; i < WF_PER_CU; i++) begin
            validCnt_d = validCnt_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q  <= '0;
            valid_q    <= '0;
            validCnt_q <= '0;
            addrErr_q  <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            valid_q    <= valid_d;
            validCnt_q <= validCnt_d;
            addrErr_q  <= addrErr_d;
        end
    end

    assign out       = entries_q;
    assign valid     = valid_q;
    assign valid_cnt = validCnt_q;
    assign addr_err  = addrErr_q;

endmodule

// File: doc/wf_ready_bits_table.md
WF_READY_BITS_TABLE -- requirements
Module: wf_ready_bits_table

Interface
REQ-001 SHALL have parameter INFO_LENGTH, default 8, width of one per-wavefront info entry.
REQ-002 SHALL have parameter WF_PER_CU, default 40, number of wavefront entries.
REQ-003 SHALL have parameter WF_ID_LENGTH, default 6, width of wavefront id ports.
REQ-004 SHALL have parameter MODE, default 0: 0 = overwrite on write, 1 = accumulate (bitwise OR) on write.
REQ-005 SHALL have one clock and a synchronous, active-high reset:
  clk  input  1  sole clock, all state updates on rising edge
  rst  input  1  synchronous active-high reset
REQ-006 SHALL have the remaining ports:
  wr0_en    input   1                         write port 0 enable
  wr0_addr  input   WF_ID_LENGTH              write port 0 wavefront id
  wr0_data  input   INFO_LENGTH               write port 0 info
  wr1_en    input   1                         write port 1 enable
  wr1_addr  input   WF_ID_LENGTH              write port 1 wavefront id
  wr1_data  input   INFO_LENGTH               write port 1 info
  clr_en    input   1                         clear enable
  clr_addr  input   WF_ID_LENGTH              clear wavefront id
  out       output  INFO_LENGTH*WF_PER_CU     registered entries; entry i at out[INFO_LENGTH*i +: INFO_LENGTH]
  valid     output  WF_PER_CU                 registered per-entry valid flags
  valid_cnt output  WF_ID_LENGTH+1            registered number of set valid bits
  addr_err  output  1                         registered one-cycle pulse, out-of-range id seen

Function
REQ-007 All outputs SHALL be registered; a request in cycle N SHALL be visible on outputs in cycle N+1; no combinational input-to-output path.
REQ-008 An enabled write to id k (k < WF_PER_CU) SHALL set valid[k]=1, including when data is zero.
REQ-009 MODE 0: an enabled write SHALL replace entry k with the write data.
REQ-010 MODE 1: an enabled write SHALL set entry k to old entry k OR write data.
REQ-011 Both write ports enabled, same id: write data combined = wr0_data | wr1_data, then applied per REQ-009/REQ-010.
REQ-012 Both write ports enabled, different ids: both entries SHALL update in the same cycle, independently.
REQ-013 An enabled clear to id k SHALL set entry k to 0 and valid[k] to 0.
REQ-014 Clear and write(s) to the same id in the same cycle: clear applied first, then write; result entry = write data (both modes), valid = 1.
REQ-015 Entries not addressed in a cycle SHALL hold their value.
REQ-016 An enabled port whose id is >= WF_PER_CU SHALL be ignored (no entry, valid or count change); other in-range ports in the same cycle SHALL still take effect.
REQ-017 addr_err SHALL be 1 in cycle N+1 iff any enabled port in cycle N has id >= WF_PER_CU; otherwise 0.
REQ-018 valid_cnt SHALL equal the population count of valid as updated at the same clock edge (always consistent with valid on the same cycle).
REQ-019 valid_cnt width SHALL hold WF_PER_CU without overflow (WF_PER_CU <= 2^(WF_ID_LENGTH+1)-1).
REQ-020 Disabled ports SHALL be ignored regardless of addr/data values, including X.

Reset
REQ-021 While rst=1 at a rising edge, out, valid, valid_cnt and addr_err SHALL all become 0 on that edge.
REQ-022 rst SHALL take priority over all same-cycle writes and clears; requests in the reset cycle SHALL be discarded.
REQ-023 The first request accepted after reset deassertion SHALL behave exactly as from an empty table.

Verification
REQ-024 MODE 0: wr0 id 3 data 0xA5, next cycle wr0 id 3 data 0x0F -> entry 3 = 0xA5 then 0x0F; valid[3]=1; valid_cnt=1.
REQ-025 MODE 1: wr0 id 39 data 0x01, then wr1 id 39 data 0x80 -> entry 39 = 0x01 then 0x81; all other entries 0.
REQ-026 Same cycle wr0 id 5 data 0x30, wr1 id 5 data 0x03, clr id 5 (entry 5 previously 0xFF) -> entry 5 = 0x33, valid[5]=1, both modes.
REQ-027 Fill ids 0..39 one per cycle, then clear id 20 and write id 40 same cycle -> valid_cnt 40 then 39, entry 20 = 0, addr_err=1 for one cycle only.
REQ-028 rst asserted mid-sequence with wr0 id 7 enabled -> next cycle out=0, valid=0, valid_cnt=0, addr_err=0; entry 7 not written.
REQ-029 Random writes/clears over 10k cycles against a reference model, both MODE values -> out, valid, valid_cnt match every cycle.
